clk_cfg_sequencer: RTL and testbench
====================================

# clk_cfg_sequencer

Arbitrated sequencer owning the `clk_div_sel` and `clk_gate_en` controls of `clock_reset_manager`. It accepts divider and gate change requests from up to NUM_REQ requesters (CSR, debug, power manager) and picks one by round-robin. Divider changes run a glitch-safe sequence: gate the CPU clock, settle, switch the divider, settle, then apply the requested gate state. It runs in the pll_clk domain and is released by the cold reset.

## Interface
- NUM_REQ, 3: number of requesters, 2..8
- GATE_SETTLE, 4: pll_clk cycles the clock is held gated before the divider switches, ≥1
- DIV_SETTLE, 8: pll_clk cycles after the divider switch before the clock is ungated, ≥1; must be ≥8 to cover a full ÷8 period
- DIV_RESET, 3'b000: divider select value after reset

Ports:
- pll_clk  in  1  clock; all logic is rising-edge
- rst_cold_async  in  1  asynchronous, active-low reset
- pll_locked  in  1  PLL lock; sequencing pauses while low
- test_mode  in  1  clocks forced from clk_ref; changes apply without a gating sequence
- req  in  NUM_REQ  per-requester request level
- req_div_sel  in  3*NUM_REQ  requested divider select; requester i uses bits [3i+2:3i]
- req_gate  in  NUM_REQ  requested final gate state (1 = gated)
- ack  out  NUM_REQ  one-cycle pulse: request applied
- nack  out  NUM_REQ  one-cycle pulse: request rejected, nothing changed
- clk_div_sel  out  3  to clock_reset_manager.clk_div_sel
- clk_gate_en  out  1  to clock_reset_manager.clk_gate_en
- busy  out  1  high whenever state ≠ IDLE
- grant_id  out  3  index of the current or last granted requester

## Operation
- Reset values: clk_div_sel = DIV_RESET, clk_gate_en = 0, ack = 0, nack = 0, busy = 0, grant_id = 0, state = IDLE, rr_ptr = 0.
- Request handshake:
  - Requester asserts req[i] and holds req_div_sel and req_gate stable until it sees ack[i] or nack[i].
  - It drops req[i] in the cycle after the pulse.
  - req is sampled only in IDLE.
- Arbitration: round-robin. Search starts at rr_ptr, and the first set req wins. In ACK/NACK, rr_ptr ← (grant + 1) mod NUM_REQ.
- Outputs clk_div_sel, clk_gate_en, ack and nack are all registered.
- FSM states: IDLE, GATE_WAIT, DIV_WAIT, ACK, NACK.
- IDLE, entered when any req is set and pll_locked = 1:
  - Latch grant, payload div (L_div) and gate (L_gate); grant_id ← grant.
  - If L_div[2] = 1 (encoding invalid): go to NACK, no output change.
  - Else if L_div == clk_div_sel, or test_mode = 1: clk_div_sel ← L_div, clk_gate_en ← L_gate, go to ACK.
  - Else: clk_gate_en ← 1, cnt ← GATE_SETTLE−1, go to GATE_WAIT.
- GATE_WAIT:
  - If pll_locked = 0, hold everything.
  - Else if cnt = 0: clk_div_sel ← L_div, cnt ← DIV_SETTLE−1, go to DIV_WAIT.
  - Else cnt−1.
- DIV_WAIT:
  - If pll_locked = 0, hold.
  - Else if cnt = 0: clk_gate_en ← L_gate, go to ACK.
  - Else cnt−1.
- ACK: ack[grant] = 1 for one cycle, then IDLE.
- NACK: nack[grant] = 1 for one cycle, then IDLE.
- cnt is a ceil(log2(max(GATE_SETTLE, DIV_SETTLE)))-bit down-counter. It never wraps; it stops at 0.
- Changes to req or payload while busy are ignored. A requester that drops req mid-sequence still gets its ack.
- test_mode changing mid-sequence has no effect on a sequence already in progress.
- Reset asserted mid-sequence: all state returns to reset values immediately (asynchronously). No ack is generated for the interrupted request.

## Timing
- A grant occurs at the IDLE cycle T.
- Full divider change:
  - clk_gate_en = 1 from T+1.
  - clk_div_sel updates at T+GATE_SETTLE+1.
  - clk_gate_en = L_gate at T+GATE_SETTLE+DIV_SETTLE+1.
  - ack is high in the same cycle.
  - With defaults: divider changes at T+5, ack at T+13.
- Same-divider, gate-only, or test_mode request: outputs update at T+1 and ack is high at T+1.
- Invalid request: nack is high at T+1.
- Each cycle with pll_locked = 0 during GATE_WAIT or DIV_WAIT adds one cycle to the latency.
- Back-to-back: the earliest next grant is in the IDLE cycle after ACK/NACK, i.e. T+2 for a fast-path request.
- The clock is never ungated while clk_div_sel can change: clk_div_sel changes only while clk_gate_en = 1, or while test_mode = 1.

## Test plan
- Reset, then requester 0 asks for div 3'b011 with gate 0, at defaults:
  - clk_gate_en goes 1 at T+1.
  - clk_div_sel = 3 at T+5.
  - clk_gate_en = 0 and ack[0] pulse at T+13.
  - busy is high from T+1 through T+13.
- Requests with the current divider:
  - req_div_sel = current value with req_gate = 1 → clk_gate_en = 1 and ack at T+1; clk_div_sel unchanged.
  - req_div_sel = 3'b101 → nack pulse at T+1 and no output change.
- Fairness: req[0], req[1] and req[2] held continuously, each re-asserted after its ack → grants come in the order 0, 1, 2, 0. grant_id matches ack every time.
- PLL lock loss: pll_locked dropped for 6 cycles during DIV_WAIT → ack is delayed by exactly 6 cycles and clk_gate_en stays 1 throughout.
- test_mode = 1 with a request for div 3'b010 → clk_div_sel = 2 at T+1, clk_gate_en is never pulsed high, ack at T+1.
- Reset mid-sequence: rst_cold_async pulsed low at T+7 → clk_div_sel returns to DIV_RESET and clk_gate_en, busy and ack return to 0 immediately. The next request starts a fresh, full sequence.

Source files
------------

// File: rtl/clk_cfg_sequencer.sv
// Round-robin arbiter and glitch-safe sequencer for the CPU clock divider and gate.
// Divider switches happen only behind a gated clock unless clocks are forced from clk_ref.
module clk_cfg_sequencer #(
  parameter int         NUM_REQ     = 3,
  parameter int         GATE_SETTLE = 4,
  parameter int         DIV_SETTLE  = 8,
  parameter logic [2:0] DIV_RESET   = 3'b000
) (
  input  logic                   pll_clk,
  input  logic                   rst_cold_async,
  input  logic                   pll_locked,
  input  logic                   test_mode,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [3*NUM_REQ-1:0]   req_div_sel,
  input  logic [NUM_REQ-1:0]     req_gate,
  output logic [NUM_REQ-1:0]     ack,
  output logic [NUM_REQ-1:0]     nack,
  output logic [2:0]             clk_div_sel,
  output logic                   clk_gate_en,
  output logic                   busy,
  output logic [2:0]             grant_id
);

  localparam int SETTLE_MAX = (GATE_SETTLE > DIV_SETTLE) ? GATE_SETTLE : DIV_SETTLE;
  localparam int CNT_W      = (SETTLE_MAX > 1) ? $clog2(SETTLE_MAX) : 1;
  localparam logic [CNT_W-1:0] GATE_LOAD = CNT_W'(GATE_SETTLE - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_SETTLE - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_GATE_WAIT = 3'd1;
  localparam logic [2:0] S_DIV_WAIT  = 3'd2;
  localparam logic [2:0] S_ACK       = 3'd3;
  localparam logic [2:0] S_NACK      = 3'd4;

  logic [2:0]         state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [2:0]         grant_reg, grant_next;
  logic [2:0]         rr_ptr_reg, rr_ptr_next;
  logic [2:0]         l_div_reg, l_div_next;
  logic               l_gate_reg, l_gate_next;
  logic [2:0]         div_reg, div_next;
  logic               gate_reg, gate_next;
  logic [NUM_REQ-1:0] ack_reg, ack_next;
  logic [NUM_REQ-1:0] nack_reg, nack_next;

  // Requests rotated so that candidate 0 is the requester at rr_ptr.
  logic [2:0]         cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_req;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    logic [3:0] sum;
    assign sum           = {1'b0, rr_ptr_reg} + 4'(gi);
    assign cand_idx[gi]  = (sum >= 4'(NUM_REQ)) ? 3'(sum - 4'(NUM_REQ)) : sum[2:0];
    assign cand_req[gi]  = |(req & (NUM_REQ'(1) << cand_idx[gi]));
  end

  logic [2:0]         grant_idx;
  logic               any_req;
  logic [NUM_REQ-1:0] grant_oh;
  logic [NUM_REQ-1:0] grant_reg_oh;
  logic [2:0]         sel_div;
  logic               sel_gate;
  logic [2:0]         rr_after_grant;

  always_comb begin
    grant_idx = '0;
    any_req   = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        grant_idx = cand_idx[k];
        any_req   = 1'b1;
      end
    end
  end

  assign grant_oh     = NUM_REQ'(1) << grant_idx;
  assign grant_reg_oh = NUM_REQ'(1) << grant_reg;

  always_comb begin
    sel_div  = '0;
    sel_gate = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_oh[k]) begin
        sel_div  = req_div_sel[3*k +: 3];
        sel_gate = req_gate[k];
      end
    end
  end

  assign rr_after_grant = (grant_reg == 3'(NUM_REQ - 1)) ? 3'd0 : grant_reg + 3'd1;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    grant_next  = grant_reg;
    rr_ptr_next = rr_ptr_reg;
    l_div_next  = l_div_reg;
    l_gate_next = l_gate_reg;
    div_next    = div_reg;
    gate_next   = gate_reg;
    ack_next    = '0;
    nack_next   = '0;
    case (state_reg)
      S_IDLE: begin
        if (any_req && pll_locked) begin
          grant_next  = grant_idx;
          l_div_next  = sel_div;
          l_gate_next = sel_gate;
          if (sel_div[2]) begin
            state_next = S_NACK;
            nack_next  = grant_oh;
          end else if (sel_div == div_reg || test_mode) begin
            div_next   = sel_div;
            gate_next  = sel_gate;
            state_next = S_ACK;
            ack_next   = grant_oh;
          end else begin
            gate_next  = 1'b1;
            cnt_next   = GATE_LOAD;
            state_next = S_GATE_WAIT;
          end
        end
      end
      S_GATE_WAIT: begin
        if (pll_locked) begin
          if (cnt_reg == '0) begin
            div_next   = l_div_reg;
            cnt_next   = DIV_LOAD;
            state_next = S_DIV_WAIT;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
      end
      S_DIV_WAIT: begin
        if (pll_locked) begin
          if (cnt_reg == '0) begin
            gate_next  = l_gate_reg;
            state_next = S_ACK;
            ack_next   = grant_reg_oh;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
      end
      S_ACK, S_NACK: begin
        rr_ptr_next = rr_after_grant;
        state_next  = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge pll_clk or negedge rst_cold_async) begin
    if (!rst_cold_async) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      grant_reg  <= '0;
      rr_ptr_reg <= '0;
      l_div_reg  <= DIV_RESET;
      l_gate_reg <= 1'b0;
      div_reg    <= DIV_RESET;
      gate_reg   <= 1'b0;
      ack_reg    <= '0;
      nack_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      grant_reg  <= grant_next;
      rr_ptr_reg <= rr_ptr_next;
      l_div_reg  <= l_div_next;
      l_gate_reg <= l_gate_next;
      div_reg    <= div_next;
      gate_reg   <= gate_next;
      ack_reg    <= ack_next;
      nack_reg   <= nack_next;
    end
  end

  assign ack         = ack_reg;
  assign nack        = nack_reg;
  assign clk_div_sel = div_reg;
  assign clk_gate_en = gate_reg;
  assign busy        = (state_reg != S_IDLE);
  assign grant_id    = grant_reg;

endmodule

// File: tb/tb_clk_cfg_sequencer.sv
// Scoreboard bench for clk_cfg_sequencer: directed requests push expected pulses,
// a negedge monitor pops and compares them against the outputs.
`timescale 1ns/1ps
module tb_clk_cfg_sequencer;

  localparam int         NUM_REQ   = 3;
  localparam logic [2:0] DIV_RESET = 3'b000;

  logic                 pll_clk = 1'b0;
  logic                 rst_cold_async = 1'b0;
  logic                 pll_locked = 1'b1;
  logic                 test_mode = 1'b0;
  logic [NUM_REQ-1:0]   req = '0;
  logic [3*NUM_REQ-1:0] req_div_sel = '0;
  logic [NUM_REQ-1:0]   req_gate = '0;
  logic [NUM_REQ-1:0]   ack, nack;
  logic [2:0]           clk_div_sel, grant_id;
  logic                 clk_gate_en, busy;

  clk_cfg_sequencer #(
    .NUM_REQ(NUM_REQ), .GATE_SETTLE(4), .DIV_SETTLE(8), .DIV_RESET(DIV_RESET)
  ) dut (
    .pll_clk(pll_clk), .rst_cold_async(rst_cold_async), .pll_locked(pll_locked),
    .test_mode(test_mode), .req(req), .req_div_sel(req_div_sel), .req_gate(req_gate),
    .ack(ack), .nack(nack), .clk_div_sel(clk_div_sel), .clk_gate_en(clk_gate_en),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 pll_clk = ~pll_clk;

  int cyc = 0;
  always @(posedge pll_clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_nack;
    int         id;
    logic [2:0] div;
    logic       gate;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int start_cyc;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic push_exp(input int id, input bit is_nack, input logic [2:0] div,
                          input logic gate, input int at_cyc);
    exp_t e;
    e.id = id; e.is_nack = is_nack; e.div = div; e.gate = gate; e.cyc = at_cyc;
    exp_q.push_back(e);
  endtask

  task automatic issue_req(input int id, input logic [2:0] div, input logic g, input int lat,
                           input bit is_nack, input logic [2:0] exp_div, input logic exp_gate);
    @(negedge pll_clk);
    req_div_sel[3*id +: 3] = div;
    req_gate[id] = g;
    req[id] = 1'b1;
    start_cyc = cyc;
    push_exp(id, is_nack, exp_div, exp_gate, cyc + lat);
  endtask

  task automatic wait_done(input int id);
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge pll_clk);
      if (ack[id] || nack[id]) break;
    end
    if (k == 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_req%0d: no ack/nack within 100 cycles", id);
    end
    req[id] = 1'b0;
  endtask

  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge pll_clk);
  endtask

  // Monitor: pulse scoreboard plus the gated-switch invariant.
  initial begin
    exp_t e;
    logic [NUM_REQ-1:0] exp_ack, exp_nack;
    logic [2:0] prev_div;
    logic prev_gate;
    prev_div  = DIV_RESET;
    prev_gate = 1'b0;
    forever begin
      @(negedge pll_clk);
      if (!rst_cold_async) begin
        prev_div  = clk_div_sel;
        prev_gate = clk_gate_en;
      end else begin
        if (clk_div_sel !== prev_div)
          check("div_change_while_ungated", 32'((prev_gate && clk_gate_en) || test_mode), 1);
        prev_div  = clk_div_sel;
        prev_gate = clk_gate_en;
        if (ack != '0 || nack != '0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", {ack, nack}, 0);
          end else begin
            e = exp_q.pop_front();
            exp_ack  = e.is_nack ? '0 : NUM_REQ'(1) << e.id;
            exp_nack = e.is_nack ? NUM_REQ'(1) << e.id : '0;
            $display("[%0d] %s req%0d grant_id=%0d div=%0d gate=%0d",
                     cyc, (nack != '0) ? "nack" : "ack", e.id, grant_id, clk_div_sel, clk_gate_en);
            check("ack_vec", ack, exp_ack);
            check("nack_vec", nack, exp_nack);
            check("grant_id", grant_id, e.id);
            check("div_sel", clk_div_sel, e.div);
            check("gate_en", clk_gate_en, e.gate);
            check("pulse_cycle", cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int done;
    bit pend, used;

    // Reset values
    repeat (3) @(negedge pll_clk);
    check("rst_div", clk_div_sel, DIV_RESET);
    check("rst_gate", clk_gate_en, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", {ack, nack}, 0);
    check("rst_grant_id", grant_id, 0);
    #2 rst_cold_async = 1'b1;
    @(negedge pll_clk);
    check("post_rst_busy", busy, 0);

    // Full divider change 0 -> 3, final gate 0
    issue_req(0, 3'd3, 1'b0, 13, 0, 3'd3, 1'b0);
    s = start_cyc;
    at_cyc(s + 1);
    check("full_gate_T1", clk_gate_en, 1);
    check("full_busy_T1", busy, 1);
    at_cyc(s + 4);
    check("full_div_T4", clk_div_sel, 0);
    at_cyc(s + 5);
    check("full_div_T5", clk_div_sel, 3);
    check("full_gate_T5", clk_gate_en, 1);
    at_cyc(s + 12);
    check("full_gate_T12", clk_gate_en, 1);
    check("full_busy_T12", busy, 1);
    wait_done(0);
    check("full_busy_T13", busy, 1);
    @(negedge pll_clk);
    check("full_busy_T14", busy, 0);

    // Same divider, gate only; then invalid encoding, back-to-back
    issue_req(1, 3'd3, 1'b1, 1, 0, 3'd3, 1'b1);
    wait_done(1);
    issue_req(2, 3'd5, 1'b0, 1, 1, 3'd3, 1'b1);
    wait_done(2);

    // Fairness: all three requesting, requester 0 re-asserts after its ack
    @(negedge pll_clk);
    s = cyc;
    req_div_sel = {3'd3, 3'd3, 3'd3};
    req_gate = 3'b010;
    req = 3'b111;
    push_exp(0, 0, 3'd3, 1'b0, s + 1);
    push_exp(1, 0, 3'd3, 1'b1, s + 3);
    push_exp(2, 0, 3'd3, 1'b0, s + 5);
    push_exp(0, 0, 3'd3, 1'b1, s + 7);
    done = 0; pend = 0; used = 0;
    for (int k = 0; k < 40 && done < 4; k++) begin
      @(negedge pll_clk);
      if (pend) begin
        req_gate[0] = 1'b1;
        req[0] = 1'b1;
        pend = 0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ack[i] || nack[i]) begin
          req[i] = 1'b0;
          done++;
          if (i == 0 && !used) begin
            used = 1;
            pend = 1;
          end
        end
      end
    end
    if (done < 4) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_fairness: %0d of 4 pulses seen", done);
    end

    // PLL lock lost for 6 cycles during DIV_WAIT
    issue_req(1, 3'd1, 1'b0, 19, 0, 3'd1, 1'b0);
    s = start_cyc;
    at_cyc(s + 6);
    pll_locked = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge pll_clk);
      check("unlocked_gate_held", clk_gate_en, 1);
    end
    pll_locked = 1'b1;
    wait_done(1);

    // test_mode: immediate divider change, no gating
    test_mode = 1'b1;
    issue_req(2, 3'd2, 1'b0, 1, 0, 3'd2, 1'b0);
    wait_done(2);
    check("tm_no_gate", clk_gate_en, 0);
    @(negedge pll_clk);
    test_mode = 1'b0;

    // Reset in the middle of a full sequence
    issue_req(0, 3'd3, 1'b0, 13, 0, 3'd3, 1'b0);
    s = start_cyc;
    at_cyc(s + 6);
    check("mid_gate_T6", clk_gate_en, 1);
    check("mid_div_T6", clk_div_sel, 3);
    at_cyc(s + 7);
    #2 rst_cold_async = 1'b0;
    #1;
    check("async_rst_div", clk_div_sel, DIV_RESET);
    check("async_rst_gate", clk_gate_en, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_ack", ack, 0);
    exp_q.delete();
    req[0] = 1'b0;
    @(negedge pll_clk);
    #2 rst_cold_async = 1'b1;

    // Fresh full sequence after reset
    issue_req(1, 3'd3, 1'b1, 13, 0, 3'd3, 1'b1);
    s = start_cyc;
    at_cyc(s + 1);
    check("fresh_gate_T1", clk_gate_en, 1);
    at_cyc(s + 4);
    check("fresh_div_T4", clk_div_sel, DIV_RESET);
    at_cyc(s + 5);
    check("fresh_div_T5", clk_div_sel, 3);
    wait_done(1);

    repeat (3) @(negedge pll_clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
